// File: rtl/soc_bus_pkg.sv
// Shared types and widths for the VAA8-S1 two-master bus arbiter.
package soc_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t M_CPU = 1'b0;
  localparam master_id_t M_DMA = 1'b1;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection for the bus arbiter.
// Tie policy: round robin when ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority to m0.
module bus_arb_pick (
  input  logic [1:0]              req_i,
  input  logic                    locked_i,
  input  soc_bus_pkg::master_id_t owner_i,
  input  logic                    hold_expired_i,
  input  soc_bus_pkg::master_id_t last_owner_i,
  output logic                    gnt_valid_o,
  output soc_bus_pkg::master_id_t winner_o
);
  import soc_bus_pkg::*;

  master_id_t other;
  master_id_t tie_winner;

  assign other = ~owner_i;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_winner = ~last_owner_i;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;
  assign tie_winner = M_CPU;
`endif

  // Lock beats everything; an expired lock hands the bus to the other master if it waits.
  always_comb begin
    gnt_valid_o = |req_i;
    winner_o    = M_CPU;
    if (locked_i && req_i[owner_i]) begin
      winner_o = owner_i;
    end else if (hold_expired_i && req_i[other]) begin
      winner_o = other;
    end else if (req_i == 2'b11) begin
      winner_o = tie_winner;
    end else if (req_i[1]) begin
      winner_o = M_DMA;
    end
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Two-master arbiter for the VAA8-S1 bus: IDLE (arbitrate) -> ACCESS -> DONE (ack).
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking inside bus_arb_pick.
module soc_bus_arbiter #(
  parameter int ADDR_W   = soc_bus_pkg::ADDR_W,
  parameter int DATA_W   = soc_bus_pkg::DATA_W,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_m0,
  input  logic                   req_m1,
  input  logic                   lock_m0,
  input  logic                   lock_m1,
  input  logic [ADDR_W-1:0]      addr_m0,
  input  logic [ADDR_W-1:0]      addr_m1,
  input  logic [DATA_W-1:0]      wdata_m0,
  input  logic [DATA_W-1:0]      wdata_m1,
  input  logic                   we_m0,
  input  logic                   we_m1,
  output logic                   gnt_m0,
  output logic                   gnt_m1,
  output logic                   ack_m0,
  output logic                   ack_m1,
  output logic [DATA_W-1:0]      rdata,
  output logic                   bus_en,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W-1:0]      bus_wdata,
  output logic                   bus_we,
  input  logic [DATA_W-1:0]      bus_rdata,
  output soc_bus_pkg::arb_state_t dbg_state
);
  import soc_bus_pkg::*;

  localparam int CNT_W = $clog2(MAX_HOLD + 2);

  arb_state_t        state_q, state_d;
  master_id_t        owner_q, owner_d;
  logic              locked_q, locked_d;
  logic              expired_q, expired_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] req_vec;
  logic [1:0] lock_vec;
  logic       pick_valid;
  master_id_t pick_winner;
  logic       lock_grant;
  logic       in_access;

  assign req_vec  = {req_m1, req_m0};
  assign lock_vec = {lock_m1, lock_m0};

  // owner_q doubles as the last winner for round-robin tie breaking.
  bus_arb_pick u_pick (
    .req_i          (req_vec),
    .locked_i       (locked_q),
    .owner_i        (owner_q),
    .hold_expired_i (expired_q),
    .last_owner_i   (owner_q),
    .gnt_valid_o    (pick_valid),
    .winner_o       (pick_winner)
  );

  assign lock_grant = locked_q && req_vec[owner_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= M_DMA;
      locked_q   <= 1'b0;
      expired_q  <= 1'b0;
      hold_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      locked_q   <= locked_d;
      expired_q  <= expired_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    locked_d   = locked_q;
    expired_d  = expired_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      IDLE: begin
        // Lock and expiry only steer this one arbitration; DONE re-evaluates the lock.
        locked_d  = 1'b0;
        expired_d = 1'b0;
        if (pick_valid) begin
          owner_d    = pick_winner;
          addr_d     = (pick_winner == M_DMA) ? addr_m1  : addr_m0;
          wdata_d    = (pick_winner == M_DMA) ? wdata_m1 : wdata_m0;
          we_d       = (pick_winner == M_DMA) ? we_m1    : we_m0;
          hold_cnt_d = lock_grant ? hold_cnt_q + CNT_W'(1) : CNT_W'(1);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = bus_rdata;
        state_d = DONE;
      end
      DONE: begin
        locked_d  = lock_vec[owner_q] && (hold_cnt_q <  CNT_W'(MAX_HOLD));
        expired_d = lock_vec[owner_q] && (hold_cnt_q >= CNT_W'(MAX_HOLD));
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign bus_en    = in_access;
  assign bus_addr  = in_access ? addr_q  : '0;
  assign bus_wdata = in_access ? wdata_q : '0;
  assign bus_we    = in_access & we_q;

  assign gnt_m0 = (state_q != IDLE) && (owner_q == M_CPU);
  assign gnt_m1 = (state_q != IDLE) && (owner_q == M_DMA);
  assign ack_m0 = (state_q == DONE) && (owner_q == M_CPU);
  assign ack_m1 = (state_q == DONE) && (owner_q == M_DMA);

  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Self-checking bench for soc_bus_arbiter (MAX_HOLD=4); follows ARB_ROUND_ROBIN_EN like the DUT.
module tb_soc_bus_arbiter;
  import soc_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_m0 = 0, req_m1 = 0, lock_m0 = 0, lock_m1 = 0;
  logic [15:0] addr_m0 = 0, addr_m1 = 0;
  logic [7:0]  wdata_m0 = 0, wdata_m1 = 0;
  logic        we_m0 = 0, we_m1 = 0;
  logic        gnt_m0, gnt_m1, ack_m0, ack_m1;
  logic [7:0]  rdata;
  logic        bus_en, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  arb_state_t  dbg_state;

  soc_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .req_m0(req_m0), .req_m1(req_m1), .lock_m0(lock_m0), .lock_m1(lock_m1),
    .addr_m0(addr_m0), .addr_m1(addr_m1), .wdata_m0(wdata_m0), .wdata_m1(wdata_m1),
    .we_m0(we_m0), .we_m1(we_m1),
    .gnt_m0(gnt_m0), .gnt_m1(gnt_m1), .ack_m0(ack_m0), .ack_m1(ack_m1),
    .rdata(rdata), .bus_en(bus_en), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Slave model: combinational read data from the address.
  function automatic logic [7:0] slave_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction
  assign bus_rdata = slave_fn(bus_addr);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {master, we, addr, wdata, expected rdata}
  logic [33:0] exp_q[$];
  int          exp_writes = 0;
  int          we_cycles  = 0;
  int          ack_seen1  = 0;

  logic [15:0] a_tab[2][12];
  logic [7:0]  d_tab[2][12];
  logic        w_tab[2][12];

  task automatic fill_tabs();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 12; k++) begin
        a_tab[m][k] = 16'($urandom_range(0, 16'hFFFF));
        d_tab[m][k] = 8'($urandom_range(0, 255));
        w_tab[m][k] = 1'($urandom_range(0, 1));
      end
  endtask

  task automatic push_exp(input int m, input int k);
    logic mid;
    mid = (m == 1);
    exp_q.push_back({mid, w_tab[m][k], a_tab[m][k], d_tab[m][k],
                     w_tab[m][k] ? 8'h00 : slave_fn(a_tab[m][k])});
    if (w_tab[m][k]) exp_writes++;
  endtask

  logic [33:0] cur;
  logic        pending = 1'b0;

  always @(negedge clk) begin
    logic was_pending;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (bus_we) we_cycles++;
      if (ack_m1) ack_seen1++;
      was_pending = pending;
      if (pending) begin
        check_eq("ack", 64'({ack_m1, ack_m0}), cur[33] ? 64'd2 : 64'd1);
        check_eq("ack_gnt", 64'({gnt_m1, gnt_m0}), cur[33] ? 64'd2 : 64'd1);
        if (!cur[32]) check_eq("rdata", 64'(rdata), 64'(cur[7:0]));
        pending = 1'b0;
      end else begin
        check_eq("stray_ack", 64'({ack_m1, ack_m0}), 64'd0);
      end
      if (bus_en) begin
        if (exp_q.size() == 0) begin
          check_eq("exp_empty", 64'd0, 64'd1);
        end else begin
          cur = exp_q.pop_front();
          check_eq("bus_addr", 64'(bus_addr), 64'(cur[31:16]));
          check_eq("bus_we", 64'(bus_we), 64'(cur[32]));
          check_eq("bus_wdata", 64'(bus_wdata), 64'(cur[15:8]));
          check_eq("acc_gnt", 64'({gnt_m1, gnt_m0}), cur[33] ? 64'd2 : 64'd1);
          pending = 1'b1;
        end
      end else begin
        check_eq("idle_bus", 64'({bus_we, bus_addr, bus_wdata}), 64'd0);
        if (!was_pending) check_eq("idle_gnt", 64'({gnt_m1, gnt_m0}), 64'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int m, input logic r, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    if (m == 0) begin req_m0 = r; we_m0 = w; addr_m0 = a; wdata_m0 = d; end
    else        begin req_m1 = r; we_m1 = w; addr_m1 = a; wdata_m1 = d; end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 8'h0);
    drive(1, 0, 0, 16'h0, 8'h0);
    lock_m0 = 0; lock_m1 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs n back-to-back transfers from the table, holding req high between them.
  task automatic run_master(input int m, input int n, output int lat);
    int   cyc;
    logic got;
    lat = -1;
    for (int k = 0; k < n; k++) begin
      drive(m, 1'b1, w_tab[m][k], a_tab[m][k], d_tab[m][k]);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 60) begin
        @(negedge clk);
        cyc++;
        got = (m == 1) ? ack_m1 : ack_m0;
      end
      check_eq(m == 1 ? "ack_wait_m1" : "ack_wait_m0", 64'(got), 64'd1);
      if (k == 0) lat = cyc;
    end
    drive(m, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic wait_gnt(input int m);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!((m == 1) ? gnt_m1 : gnt_m0) && cyc < 60);
    check_eq("gnt_wait", 64'((m == 1) ? gnt_m1 : gnt_m0), 64'd1);
  endtask

  // ---------------- tests ----------------
  initial begin
    int lat0, lat1, ack1_before, we_before;

    apply_reset();
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    check_eq("rst_outs", 64'({gnt_m0, gnt_m1, ack_m0, ack_m1, bus_en, bus_we}), 64'd0);
    check_eq("rst_bus", 64'({bus_addr, bus_wdata, rdata}), 64'd0);

    // Both masters request continuously straight after reset.
    fill_tabs();
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      push_exp(0, k);
      push_exp(1, k);
    end
    fork
      run_master(0, 4, lat0);
      run_master(1, 4, lat1);
    join
`else
    for (int k = 0; k < 10; k++) push_exp(0, k);
    ack1_before = ack_seen1;
    drive(1, 1'b1, w_tab[1][0], a_tab[1][0], d_tab[1][0]);
    run_master(0, 10, lat0);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    check_eq("m1_starved", 64'(ack_seen1 - ack1_before), 64'd0);
`endif
    repeat (3) @(negedge clk);

    // m0 read of 0x0010.
    a_tab[0][0] = 16'h0010; w_tab[0][0] = 1'b0; d_tab[0][0] = 8'h5A;
    push_exp(0, 0);
    run_master(0, 1, lat0);
    check_eq("rd_lat", 64'(lat0), 64'd2);
    check_eq("rd_0010", 64'(rdata), 64'hA5);
    repeat (2) @(negedge clk);

    // m1 write of 0x3C to 0x8001.
    a_tab[1][0] = 16'h8001; w_tab[1][0] = 1'b1; d_tab[1][0] = 8'h3C;
    we_before = we_cycles;
    push_exp(1, 0);
    run_master(1, 1, lat1);
    check_eq("wr_lat", 64'(lat1), 64'd2);
    repeat (2) @(negedge clk);
    check_eq("wr_we_cycles", 64'(we_cycles - we_before), 64'd1);

    // m1 locked run capped at 4, m0 waiting.
    fill_tabs();
    for (int k = 0; k < 4; k++) push_exp(1, k);
    push_exp(0, 0);
    push_exp(1, 4);
    push_exp(1, 5);
    lock_m1 = 1'b1;
    fork
      run_master(1, 6, lat1);
      begin
        wait_gnt(1);
        run_master(0, 1, lat0);
      end
    join
    lock_m1 = 1'b0;
    repeat (3) @(negedge clk);

    // m0 lock released by dropping req while m1 waits.
    fill_tabs();
    a_tab[1][0] = 16'h0010; w_tab[1][0] = 1'b0;
    push_exp(0, 0);
    push_exp(1, 0);
    lock_m0 = 1'b1;
    fork
      run_master(0, 1, lat0);
      begin
        wait_gnt(0);
        run_master(1, 1, lat1);
      end
    join
    lock_m0 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in ACCESS abandons the transfer immediately.
    fill_tabs();
    a_tab[1][0] = 16'h4242; w_tab[1][0] = 1'b0;
    push_exp(1, 0);
    drive(1, 1'b1, 1'b0, a_tab[1][0], d_tab[1][0]);
    lat1 = 0;
    do begin
      @(negedge clk);
      lat1++;
    end while (!bus_en && lat1 < 20);
    check_eq("pre_rst_en", 64'(bus_en), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_outs", 64'({bus_en, gnt_m0, gnt_m1, ack_m0, ack_m1}), 64'd0);
    check_eq("arst_rdata", 64'(rdata), 64'd0);
    check_eq("arst_state", 64'(dbg_state), 64'(IDLE));
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    a_tab[1][0] = 16'h1357; w_tab[1][0] = 1'b0;
    push_exp(1, 0);
    run_master(1, 1, lat1);
    check_eq("post_rst_lat", 64'(lat1), 64'd2);
    repeat (2) @(negedge clk);

    // Random isolated transfers.
    fill_tabs();
    for (int i = 0; i < 8; i++) begin
      int m;
      m = $urandom_range(0, 1);
      push_exp(m, 0);
      run_master(m, 1, lat0);
      check_eq("rand_lat", 64'(lat0), 64'd2);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      fill_tabs();
    end

    repeat (3) @(negedge clk);
    check_eq("exp_drained", 64'(exp_q.size()), 64'd0);
    check_eq("we_total", 64'(we_cycles), 64'(exp_writes));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
